// File: rtl/fft16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft16_pkg
// Description : Shared definitions for the 16-point FFT parallel-to-serial
//               output sequencer: beat-counter codes, sequencer state type
//               and the beat-to-bin mapping.
// Revision    : 1.0  initial release
// ============================================================================
package fft16_pkg;

  // Beat-counter codes seen by the parallel-to-serial stage.
  localparam logic [3:0] CNT_IDLE = 4'b1000;  // stage outputs zero, capture held
  localparam logic [3:0] CNT_LOAD = 4'b0100;  // first beat, parallel capture
  localparam logic [3:0] CNT_LAST = 4'b0011;  // last beat of a frame

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Lane-0 bin for a running beat code. The stage starts at code 4, so the
  // beat ordinal is cnt[2:0] with bit 2 inverted; the emitted bin is that
  // ordinal bit-reversed (0,4,2,6,1,5,3,7).
  function automatic logic [3:0] bin_of_cnt(input logic [2:0] c);
    logic [2:0] beat;
    beat = {~c[2], c[1:0]};
    return {1'b0, beat[0], beat[1], beat[2]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft16_p2s_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fft16_p2s_ctrl
// Description : Sequencer for the FFT16 parallel-to-serial output stage.
//               Accepts whole frames with valid/ready, drives the stage beat
//               counter and load strobe, and emits framing sideband aligned
//               with the stage's registered two-bin-per-beat output.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               frame_valid/ready - frame handshake from butterfly array
//               flush             - synchronous abort back to idle
//               cnt, load         - beat counter / capture strobe to stage
//               out_valid/sop/eop - serial pair framing (1-cycle delayed)
//               out_idx           - lane-0 bin index (lane 1 = idx + 8)
//               frames_done       - wrapping count of fully emitted frames
// Revision    : 1.0  initial release
// ============================================================================
module fft16_p2s_ctrl
  import fft16_pkg::*;
#(
  parameter int BEATS  = 8,
  parameter int FCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_valid,
  output logic              frame_ready,
  input  logic              flush,
  output logic [3:0]        cnt,
  output logic              load,
  output logic              out_valid,
  output logic              out_sop,
  output logic              out_eop,
  output logic [3:0]        out_idx,
  output logic [FCNT_W-1:0] frames_done
);

  // Running codes wrap within the low three bits (7 -> 0).
  localparam logic [3:0] BEAT_MASK = 4'(BEATS - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                out_valid_q, out_valid_d;
  logic                out_sop_q, out_sop_d;
  logic                out_eop_q, out_eop_d;
  logic [3:0]          out_idx_q, out_idx_d;
  logic [FCNT_W-1:0]   frames_done_q, frames_done_d;
  logic                accept;

  // Ready only when the stage can take a new capture on the next beat: idle,
  // or on the final beat so frames run back to back. Flush and reset win.
  assign frame_ready = !rst && !flush && ((state_q == IDLE) || (cnt_q == CNT_LAST));
  assign accept      = frame_valid && frame_ready;
  assign load        = (cnt_q == CNT_LOAD);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    out_valid_d   = 1'b0;
    out_sop_d     = 1'b0;
    out_eop_d     = 1'b0;
    out_idx_d     = 4'd0;
    frames_done_d = frames_done_q + {{(FCNT_W-1){1'b0}}, out_eop_q};

    // Sideband for the beat currently on cnt; it appears one cycle later,
    // together with the stage's registered data for that beat.
    if (state_q == RUN) begin
      out_valid_d = 1'b1;
      out_sop_d   = (cnt_q == CNT_LOAD);
      out_eop_d   = (cnt_q == CNT_LAST);
      out_idx_d   = bin_of_cnt(cnt_q[2:0]);
    end

    if (flush) begin
      // Drop the in-flight beat's sideband too, so no stray valid follows.
      state_d     = IDLE;
      cnt_d       = CNT_IDLE;
      out_valid_d = 1'b0;
      out_sop_d   = 1'b0;
      out_eop_d   = 1'b0;
      out_idx_d   = 4'd0;
    end else if (state_q == IDLE) begin
      if (accept) begin
        state_d = RUN;
        cnt_d   = CNT_LOAD;
      end
    end else if (cnt_q == CNT_LAST) begin
      if (accept) begin
        cnt_d = CNT_LOAD;
      end else begin
        state_d = IDLE;
        cnt_d   = CNT_IDLE;
      end
    end else begin
      cnt_d = (cnt_q + 4'd1) & BEAT_MASK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= CNT_IDLE;
      out_valid_q   <= 1'b0;
      out_sop_q     <= 1'b0;
      out_eop_q     <= 1'b0;
      out_idx_q     <= 4'd0;
      frames_done_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      out_valid_q   <= out_valid_d;
      out_sop_q     <= out_sop_d;
      out_eop_q     <= out_eop_d;
      out_idx_q     <= out_idx_d;
      frames_done_q <= frames_done_d;
    end
  end

  assign cnt         = cnt_q;
  assign out_valid   = out_valid_q;
  assign out_sop     = out_sop_q;
  assign out_eop     = out_eop_q;
  assign out_idx     = out_idx_q;
  assign frames_done = frames_done_q;

endmodule
`default_nettype wire

// File: tb/tb_fft16_p2s_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft16_p2s_ctrl
// Description : Self-checking bench for fft16_p2s_ctrl. A behavioural model
//               tracks the beat counter; every accepted frame pushes its
//               eight expected output beats to a scoreboard queue that is
//               popped as the DUT emits pairs.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fft16_p2s_ctrl;

  localparam int FCNT_W = 16;

  typedef struct {
    logic [3:0] idx;
    logic       sop;
    logic       eop;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              frame_valid = 1'b0;
  logic              flush = 1'b0;
  logic              frame_ready;
  logic [3:0]        cnt;
  logic              load;
  logic              out_valid;
  logic              out_sop;
  logic              out_eop;
  logic [3:0]        out_idx;
  logic [FCNT_W-1:0] frames_done;

  fft16_p2s_ctrl #(.BEATS(8), .FCNT_W(FCNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .flush       (flush),
    .cnt         (cnt),
    .load        (load),
    .out_valid   (out_valid),
    .out_sop     (out_sop),
    .out_eop     (out_eop),
    .out_idx     (out_idx),
    .frames_done (frames_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  beat_t      sb[$];
  logic [3:0] bin_order [8] = '{4'd0, 4'd4, 4'd2, 4'd6, 4'd1, 4'd5, 4'd3, 4'd7};
  logic       m_idle = 1'b1;
  logic [3:0] m_cnt  = 4'd8;
  logic       m_ov   = 1'b0;
  int         m_accepts = 0;

  function automatic logic m_ready();
    return !rst && !flush && (m_idle || m_cnt == 4'd3);
  endfunction

  always @(posedge clk) begin
    logic acc;
    acc  = frame_valid && m_ready();
    m_ov <= !rst && !flush && !m_idle;
    if (rst || flush) begin
      m_idle <= 1'b1;
      m_cnt  <= 4'd8;
      sb.delete();
    end else if (acc) begin
      m_idle <= 1'b0;
      m_cnt  <= 4'd4;
      m_accepts <= m_accepts + 1;
      for (int b = 0; b < 8; b++) begin
        beat_t e;
        e.idx = bin_order[b];
        e.sop = (b == 0);
        e.eop = (b == 7);
        sb.push_back(e);
      end
    end else if (!m_idle) begin
      if (m_cnt == 4'd3) begin
        m_idle <= 1'b1;
        m_cnt  <= 4'd8;
      end else begin
        m_cnt <= (m_cnt + 4'd1) & 4'd7;
      end
    end
  end

  // ---------------- monitor (samples mid-cycle) ----------------
  int run_len = 0;
  int max_run = 0;
  int eop_seen = 0;
  bit mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      check("cnt", 32'(cnt), 32'(m_cnt));
      check("load", 32'(load), 32'(m_cnt == 4'd4));
      check("frame_ready", 32'(frame_ready), 32'(m_ready()));
      check("out_valid", 32'(out_valid), 32'(m_ov));
      if (out_valid === 1'b1) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (out_eop === 1'b1) eop_seen++;
        if (sb.size() == 0) begin
          check("sb_nonempty", 32'd0, 32'd1);
        end else begin
          beat_t e;
          e = sb.pop_front();
          check("out_idx", 32'(out_idx), 32'(e.idx));
          check("out_sop", 32'(out_sop), 32'(e.sop));
          check("out_eop", 32'(out_eop), 32'(e.eop));
        end
      end else begin
        run_len = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Stay in the cycle where the model's cnt equals v (bounded wait).
  task automatic wait_cnt(input logic [3:0] v);
    int k;
    k = 0;
    while (m_cnt != v && k < 30) begin
      step(1);
      k++;
    end
    if (m_cnt != v) check("wait_cnt_timeout", 32'(m_cnt), 32'(v));
  endtask

  task automatic wait_accepts(input int target);
    int k;
    k = 0;
    while (m_accepts < target && k < 60) begin
      step(1);
      k++;
    end
    if (m_accepts < target) check("accept_timeout", 32'(m_accepts), 32'(target));
  endtask

  task automatic send_one();
    int base;
    base = m_accepts;
    frame_valid = 1'b1;
    wait_accepts(base + 1);
    frame_valid = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int base_eop;
    step(2);
    mon_en = 1'b1;
    #4;  // mid-cycle, still in reset
    check("rst_cnt", 32'(cnt), 32'h8);
    check("rst_load", 32'(load), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_idx", 32'(out_idx), 32'h0);
    check("rst_fdone", 32'(frames_done), 32'h0);
    check("rst_ready", 32'(frame_ready), 32'h0);
    step(1);
    rst = 1'b0;
    step(2);

    // Single frame
    send_one();
    step(12);
    check("single_fdone", 32'(frames_done), 32'd1);
    check("single_sb_empty", 32'(sb.size()), 32'd0);

    // Back-to-back, three frames
    max_run = 0;
    frame_valid = 1'b1;
    wait_accepts(4);
    frame_valid = 1'b0;
    step(12);
    check("b2b_run", 32'(max_run), 32'd24);
    check("b2b_fdone", 32'(frames_done), 32'd4);

    // Gap between frames
    send_one();
    wait_cnt(4'd8);
    step(5);
    check("gap_cnt", 32'(cnt), 32'h8);
    check("gap_valid", 32'(out_valid), 32'h0);
    send_one();
    step(12);
    check("gap_fdone", 32'(frames_done), 32'd6);

    // Flush at cnt = 6
    send_one();
    wait_cnt(4'd6);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    check("flush_cnt", 32'(cnt), 32'h8);
    check("flush_valid", 32'(out_valid), 32'h0);
    step(12);
    check("flush_fdone", 32'(frames_done), 32'd6);
    send_one();
    step(12);
    check("post_flush_fdone", 32'(frames_done), 32'd7);

    // Flush with frame_valid while idle
    frame_valid = 1'b1;
    flush = 1'b1;
    #3;
    check("flush_idle_ready", 32'(frame_ready), 32'h0);
    step(1);
    frame_valid = 1'b0;
    flush = 1'b0;
    check("flush_idle_cnt", 32'(cnt), 32'h8);
    step(3);
    check("flush_idle_stay", 32'(cnt), 32'h8);

    // Reset mid-frame at cnt = 1
    send_one();
    wait_cnt(4'd1);
    base_eop = eop_seen;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("mrst_cnt", 32'(cnt), 32'h8);
    check("mrst_valid", 32'(out_valid), 32'h0);
    check("mrst_sop", 32'(out_sop), 32'h0);
    check("mrst_eop", 32'(out_eop), 32'h0);
    check("mrst_idx", 32'(out_idx), 32'h0);
    check("mrst_fdone", 32'(frames_done), 32'h0);
    step(12);
    check("mrst_no_eop", 32'(eop_seen), 32'(base_eop));
    check("mrst_fdone_after", 32'(frames_done), 32'h0);

    // Normal operation after reset
    send_one();
    step(12);
    check("final_fdone", 32'(frames_done), 32'd1);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
